time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Button front end for the sec/min/hour time counter. It synchronises and debounces
//  three raw push-buttons and runs a set-mode FSM. Outputs are the counter's control inputs:
//  adjust_sec/min/hour, clear and keep. Sits between board pins and the counter, same clk.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  clk cycles a synchronised button level must hold before acceptance
//  REPEAT_DELAY     500000 held-inc cycles before the first auto-repeat pulse (AUTO_REPEAT_EN)
//  REPEAT_PERIOD    125000 cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN)
// PORTS
//  clk          in   1  system clock; all logic on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  btn_mode     in   1  raw mode button, active-high, asynchronous to clk
//  btn_inc      in   1  raw increment button, active-high, asynchronous
//  btn_clr      in   1  raw clear button, active-high, asynchronous
//  adjust_sec   out  1  one-cycle increment pulse to seconds counter
//  adjust_min   out  1  one-cycle increment pulse to minutes counter
//  adjust_hour  out  1  one-cycle increment pulse to hours counter
//  clear        out  1  one-cycle clear pulse to all counters
//  keep         out  1  level; high freezes normal counting while in a SET state
//  mode         out  2  current state: 0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
// BEHAVIOUR
//  Reset: state RUN. All outputs 0, including mode=0. Synchronisers and debounced levels 0.
//  Reset applies asynchronously at any time, including mid-debounce or mid-repeat.
//  Input path per button: 2-flop synchroniser, then debounce counter.
//   The counter restarts whenever the synchronised level differs from the debounced level.
//   On reaching DEBOUNCE_CYCLES the debounced level updates.
//   A 0->1 debounced edge gives a one-cycle press event.
//   Press latency from a clean raw edge: 2 + DEBOUNCE_CYCLES + 1 cycles. Release makes no event.
//   Glitches shorter than DEBOUNCE_CYCLES produce no event.
//  FSM, mode press: RUN->SET_SEC->SET_MIN->SET_HOUR->RUN.
//  keep = (state != RUN), registered. It changes the cycle after the press event.
//  inc press: in SET_SEC/SET_MIN/SET_HOUR it pulses adjust_sec/min/hour for exactly 1 cycle.
//   In RUN it is ignored.
//  clr press: clear pulses for 1 cycle in any state. State is unchanged.
//  Output pulses are registered and appear the cycle after the press event.
//  Priority when press events coincide: clr > mode > inc. Lower-priority events that cycle are
//   dropped, not queued. A held button produces no further mode/clr events until released.
//  At most one of adjust_* is high in any cycle. Wrap of time values is the counter's job.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//   The repeat counter starts after an inc press in a SET state while btn_inc stays debounced-high.
//   Extra adjust pulses at REPEAT_DELAY, then every REPEAT_PERIOD cycles.
//   Repeat stops on release, a mode press, clr or reset.
//  AUTO_REPEAT_EN undefined: exactly one adjust pulse per press.
//   REPEAT_* parameters are unused and no repeat counter is synthesised.
// STRUCTURE
//  Shared package clock_pkg: mode state encoding (RUN/SET_SEC/SET_MIN/SET_HOUR, 2 bits), the
//   mode width constant and default debounce/repeat constants, shared with the display path.
//  Sub-module btn_debounce (synchroniser, debounce counter, press-edge output), instantiated
//   three times. FSM, repeat logic and output registers live in the top.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  1 rst_n low mid-sequence with btn_inc held -> all outputs 0 and mode=0 immediately;
//    no pulse after release of reset until a new debounced press.
//  2 btn_mode clean press x4 -> mode 1,2,3,0. keep=1 only in modes 1-3; each step 7 cycles
//    after the raw edge.
//  3 mode=2, btn_inc press -> single 1-cycle adjust_min. adjust_sec/adjust_hour stay 0.
//    Same press in mode=0 -> no pulse.
//  4 btn_inc 1-cycle and 3-cycle glitches -> no adjust pulse.
//    btn_clr held 10 cycles -> exactly one clear pulse, mode unchanged.
//  5 btn_clr and btn_mode raw edges in the same cycle in mode=1 -> clear pulse, mode stays 1.
//  6 AUTO_REPEAT_EN, mode=3, btn_inc held 40 cycles -> first adjust_hour, another 20 cycles
//    later, then every 5 cycles until release. Macro undefined: one pulse only.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock-project definitions: set-mode encoding, control payload and default timing.
// Used by the button front end and the display path.
package clock_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_RUN      = 2'd0;
    localparam logic [MODE_W-1:0] MODE_SET_SEC  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_SET_HOUR = 2'd3;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 500000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 125000;

    // Control word handed to the time counter each cycle.
    typedef struct packed {
        logic adjust_sec;
        logic adjust_min;
        logic adjust_hour;
        logic clear;
        logic keep;
    } ctrl_t;

    // Mode sequence RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN relies on the 2-bit wrap.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur);
        return cur + MODE_W'(1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Board-side buttons and counter-side control outputs of the time-set front end.
// master = board/stimulus side, slave = time_set_ctrl.
interface time_set_ctrl_if;
    import clock_pkg::*;

    logic              btn_mode;
    logic              btn_inc;
    logic              btn_clr;
    logic              adjust_sec;
    logic              adjust_min;
    logic              adjust_hour;
    logic              clear;
    logic              keep;
    logic [MODE_W-1:0] mode;

    modport master (
        output btn_mode, btn_inc, btn_clr,
        input  adjust_sec, adjust_min, adjust_hour, clear, keep, mode
    );

    modport slave (
        input  btn_mode, btn_inc, btn_clr,
        output adjust_sec, adjust_min, adjust_hour, clear, keep, mode
    );

endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// One push-button input path: 2-flop synchroniser, hold-time debounce and a press strobe.
// press_c is high for the single cycle after the debounced level rises.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_d1_q;

    // Raw pin is asynchronous to clk; sync_q[1] is the first usable sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    // Counter only runs while the synchronised level disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d1_q <= 1'b0;
        end else begin
            level_d1_q <= level_q;
        end
    end

    assign level   = level_q;
    assign press_c = level_q & ~level_d1_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode front end for the sec/min/hour counter: debounced buttons, mode FSM, control pulses.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat of adjust pulses while inc is held.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic           clk,
    input  logic           rst_n,
    time_set_ctrl_if.slave bus
);

    // Zero-length timing would make the hold and repeat comparisons underflow.
    if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_params
        $error("time_set_ctrl: timing parameters must be non-zero");
    end

    logic mode_press_c;
    logic inc_press_c;
    logic clr_press_c;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (bus.btn_mode),
        .level   (),
        .press_c (mode_press_c)
    );

`ifdef AUTO_REPEAT_EN
    logic inc_level;
`endif

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (bus.btn_inc),
`ifdef AUTO_REPEAT_EN
        .level   (inc_level),
`else
        .level   (),
`endif
        .press_c (inc_press_c)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (bus.btn_clr),
        .level   (),
        .press_c (clr_press_c)
    );

    logic [MODE_W-1:0] state_q;
    logic [MODE_W-1:0] state_d;
    ctrl_t             out_q;
    ctrl_t             out_d;
    logic              adj_c;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic             rep_on_q;
    logic             rep_on_d;
    logic             rep_first_q;
    logic             rep_first_d;
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic [REP_W-1:0] rep_lim_c;

    assign rep_lim_c = rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_on_q    <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            rep_on_q    <= rep_on_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_RUN;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Press priority clr > mode > inc; losing events in the same cycle are discarded.
    always_comb begin
        state_d = state_q;
        out_d   = '0;
        adj_c   = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_on_d    = rep_on_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
`endif
        if (clr_press_c) begin
            out_d.clear = 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_on_d = 1'b0;
`endif
        end else if (mode_press_c) begin
            state_d = next_mode(state_q);
`ifdef AUTO_REPEAT_EN
            rep_on_d = 1'b0;
`endif
        end else if (inc_press_c && (state_q != MODE_RUN)) begin
            adj_c = 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_on_d    = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
`endif
        end
`ifdef AUTO_REPEAT_EN
        else if (rep_on_q) begin
            if (!inc_level) begin
                rep_on_d = 1'b0;
            end else if (rep_cnt_q == rep_lim_c) begin
                adj_c       = 1'b1;
                rep_first_d = 1'b0;
                rep_cnt_d   = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
`endif
        out_d.keep        = (state_d != MODE_RUN);
        out_d.adjust_sec  = adj_c && (state_q == MODE_SET_SEC);
        out_d.adjust_min  = adj_c && (state_q == MODE_SET_MIN);
        out_d.adjust_hour = adj_c && (state_q == MODE_SET_HOUR);
    end

    assign bus.adjust_sec  = out_q.adjust_sec;
    assign bus.adjust_min  = out_q.adjust_min;
    assign bus.adjust_hour = out_q.adjust_hour;
    assign bus.clear       = out_q.clear;
    assign bus.keep        = out_q.keep;
    assign bus.mode        = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: per-cycle reference model, table of press scenarios,
// directed multi-cycle sequences and a randomized button phase.
module tb_time_set_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nchk  = 0;
    int npass = 0;
    int cyc   = 0;
    int n_sec, n_min, n_hour, n_clr;
    int hour_t[$];

    // Reference model: a button is accepted once its 2-cycle-delayed samples have all shown
    // the new value for D consecutive cycles; outputs follow the accepted events by one cycle.
    logic [D+1:0] h_mode, h_inc, h_clr;
    logic         d_mode, d_inc, d_clr;
    logic         e_mode, e_inc, e_clr;
    logic         nd;
    logic         m_sec, m_min, m_hour, m_clr;
    int           st, t0, kcyc, dt;
    bit           ract;
    logic [6:0]   exp_o;

    function automatic logic deb_next(input logic [D+1:0] h, input logic d);
        return (h[D+1:2] == {D{~d}}) ? ~d : d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_mode = '0; h_inc = '0; h_clr = '0;
            d_mode = 0;  d_inc = 0;  d_clr = 0;
            e_mode = 0;  e_inc = 0;  e_clr = 0;
            st = 0; t0 = 0; kcyc = 0; ract = 0;
            exp_o = '0;
        end else begin
            kcyc++;
            m_sec = 0; m_min = 0; m_hour = 0; m_clr = 0;
            if (e_clr) begin
                m_clr = 1; ract = 0;
            end else if (e_mode) begin
                st = (st + 1) % 4; ract = 0;
            end else if (e_inc && st != 0) begin
                m_sec = (st == 1); m_min = (st == 2); m_hour = (st == 3);
`ifdef AUTO_REPEAT_EN
                ract = 1; t0 = kcyc;
`endif
            end else if (ract) begin
                dt = kcyc - t0;
                if (!d_inc) ract = 0;
                else if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) begin
                    m_sec = (st == 1); m_min = (st == 2); m_hour = (st == 3);
                end
            end
            exp_o = {m_sec, m_min, m_hour, m_clr, 1'(st != 0), 2'(st)};
            h_mode = {h_mode[D:0], bus.btn_mode};
            h_inc  = {h_inc[D:0],  bus.btn_inc};
            h_clr  = {h_clr[D:0],  bus.btn_clr};
            nd = deb_next(h_mode, d_mode); e_mode = nd & ~d_mode; d_mode = nd;
            nd = deb_next(h_inc,  d_inc);  e_inc  = nd & ~d_inc;  d_inc  = nd;
            nd = deb_next(h_clr,  d_clr);  e_clr  = nd & ~d_clr;  d_clr  = nd;
        end
    end

    function automatic logic [6:0] dut_out();
        return {bus.adjust_sec, bus.adjust_min, bus.adjust_hour, bus.clear, bus.keep, bus.mode};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check("model", int'(dut_out()), int'(exp_o));
        if (bus.adjust_sec)  n_sec++;
        if (bus.adjust_min)  n_min++;
        if (bus.adjust_hour) begin n_hour++; hour_t.push_back(cyc); end
        if (bus.clear)       n_clr++;
    endtask

    task automatic zero();
        n_sec = 0; n_min = 0; n_hour = 0; n_clr = 0;
        hour_t.delete();
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bus.btn_mode = v;
            1:       bus.btn_inc  = v;
            default: bus.btn_clr  = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        repeat (hold) tick();
        set_btn(b, 1'b0);
        repeat (14) tick();
    endtask

    typedef struct {
        int btn;      // 0 mode, 1 inc, 2 clr
        int hold;
        int e_mode;
        int e_sec;
        int e_min;
        int e_hour;
        int e_clr;
    } vec_t;

    vec_t tbl[12];
    int   c0, exp_n, old_m, new_m;
    int   rem[3];
    logic val[3];

    initial begin
        tbl[0]  = '{1, 8,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 8,  1, 0, 0, 0, 0};
        tbl[2]  = '{1, 8,  1, 1, 0, 0, 0};
        tbl[3]  = '{0, 8,  2, 0, 0, 0, 0};
        tbl[4]  = '{1, 8,  2, 0, 1, 0, 0};
        tbl[5]  = '{1, 1,  2, 0, 0, 0, 0};
        tbl[6]  = '{1, 3,  2, 0, 0, 0, 0};
        tbl[7]  = '{2, 10, 2, 0, 0, 0, 1};
        tbl[8]  = '{0, 8,  3, 0, 0, 0, 0};
        tbl[9]  = '{1, 8,  3, 0, 0, 1, 0};
        tbl[10] = '{0, 8,  0, 0, 0, 0, 0};
        tbl[11] = '{1, 6,  0, 0, 0, 0, 0};

        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_clr = 0;
        zero();
        repeat (3) tick();
        check("reset_out", int'(dut_out()), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Mode stepping with exact latency from the raw edge.
        for (int i = 0; i < 4; i++) begin
            old_m = i;
            new_m = (i + 1) % 4;
            bus.btn_mode = 1'b1;
            repeat (6) tick();
            check("step_early_mode", int'(bus.mode), old_m);
            tick();
            check("step_mode", int'(bus.mode), new_m);
            check("step_keep", int'(bus.keep), int'(new_m != 0));
            bus.btn_mode = 1'b0;
            repeat (12) tick();
        end

        for (int i = 0; i < 12; i++) begin
            zero();
            press(tbl[i].btn, tbl[i].hold);
            check($sformatf("tbl%0d_mode", i), int'(bus.mode), tbl[i].e_mode);
            check($sformatf("tbl%0d_sec", i),  n_sec,  tbl[i].e_sec);
            check($sformatf("tbl%0d_min", i),  n_min,  tbl[i].e_min);
            check($sformatf("tbl%0d_hour", i), n_hour, tbl[i].e_hour);
            check($sformatf("tbl%0d_clr", i),  n_clr,  tbl[i].e_clr);
        end

        // clr and mode pressed together: clr wins, mode press is dropped.
        press(0, 8);
        zero();
        bus.btn_clr = 1'b1; bus.btn_mode = 1'b1;
        repeat (8) tick();
        bus.btn_clr = 1'b0; bus.btn_mode = 1'b0;
        repeat (14) tick();
        check("coinc_clr", n_clr, 1);
        check("coinc_mode", int'(bus.mode), 1);

        // Long inc hold in SET_HOUR.
        press(0, 8);
        press(0, 8);
        check("hold_pre_mode", int'(bus.mode), 3);
        zero();
        c0 = cyc;
        bus.btn_inc = 1'b1;
        repeat (40) tick();
        bus.btn_inc = 1'b0;
        repeat (30) tick();
`ifdef AUTO_REPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        check("hold_count", hour_t.size(), exp_n);
        check("hold_other", n_sec + n_min + n_clr, 0);
        if (hour_t.size() > 0) check("hold_first_lat", hour_t[0] - c0, 7);
        for (int i = 1; i < hour_t.size(); i++)
            check($sformatf("hold_gap%0d", i), hour_t[i] - hour_t[i-1], (i == 1) ? int'(RD) : int'(RP));
        press(0, 8);

        // Asynchronous reset mid-debounce with inc held.
        press(0, 8);
        press(0, 8);
        zero();
        bus.btn_inc = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check("reset_async", int'(dut_out()), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (15) tick();
        bus.btn_inc = 1'b0;
        repeat (10) tick();
        check("post_reset_adj", n_sec + n_min + n_hour, 0);
        check("post_reset_mode", int'(bus.mode), 0);

        // Randomized button activity against the model.
        for (int b = 0; b < 3; b++) begin rem[b] = 0; val[b] = 1'b0; end
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    val[b] = ~val[b];
                    rem[b] = int'($urandom_range(1, 14));
                    set_btn(b, val[b]);
                end
                rem[b]--;
            end
            tick();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
